// File: rtl/scan_ctrl.sv
// Scan-chain sequencer: shift in a pattern, pulse one capture cycle, shift out the response.
// Define SCAN_CTRL_MISR_EN to compress the unload into an accumulating MISR signature.
module scan_ctrl #(
    parameter int                   CHAIN_LEN = 16,
    parameter logic [CHAIN_LEN-1:0] MISR_POLY = 16'h002D
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic                 scan_so,
    output logic                 scan_en,
    output logic                 scan_si,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_CAPTURE   = 3'd2,
        S_SHIFT_OUT = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_q, pat_d;
    logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_si_q, scan_si_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef SCAN_CTRL_MISR_EN
    logic [CHAIN_LEN-1:0] sig_q, sig_d;

    function automatic logic [CHAIN_LEN-1:0] misr_step(input logic [CHAIN_LEN-1:0] sig,
                                                       input logic din);
        misr_step = {sig[CHAIN_LEN-2:0], 1'b0}
                  ^ ({CHAIN_LEN{sig[CHAIN_LEN-1]}} & MISR_POLY)
                  ^ {{(CHAIN_LEN-1){1'b0}}, din};
    endfunction
`endif

    // Next-state logic; outputs are derived from the next state so they come out of flops.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shadow_d  = shadow_q;
        resp_d    = resp_q;
        scan_si_d = 1'b0;
`ifdef SCAN_CTRL_MISR_EN
        sig_d     = sig_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_SHIFT_IN;
                    pat_d     = pattern;
                    scan_si_d = pattern[CHAIN_LEN-1];
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SHIFT_IN: begin
                if (cnt_q == LAST) begin
                    state_d   = S_CAPTURE;
                end else begin
                    pat_d     = {pat_q[CHAIN_LEN-2:0], 1'b0};
                    scan_si_d = pat_q[CHAIN_LEN-2];
                end
            end
            S_CAPTURE: begin
                state_d = S_SHIFT_OUT;
            end
            S_SHIFT_OUT: begin
                shadow_d = {shadow_q[CHAIN_LEN-2:0], scan_so};
`ifdef SCAN_CTRL_MISR_EN
                sig_d    = misr_step(sig_q, scan_so);
`endif
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
`ifdef SCAN_CTRL_MISR_EN
                    resp_d  = sig_d;
`else
                    resp_d  = shadow_d;
`endif
                end else begin
                    state_d = S_SHIFT_OUT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counter restarts on every state entry and idles at zero.
        if ((state_d != state_q) || (state_q == S_IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        scan_en_d = (state_d == S_SHIFT_IN) || (state_d == S_SHIFT_OUT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // State and registered outputs; reset clears everything except the chain itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            shadow_q  <= '0;
            resp_q    <= '0;
            scan_en_q <= 1'b0;
            scan_si_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SCAN_CTRL_MISR_EN
            sig_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            shadow_q  <= shadow_d;
            resp_q    <= resp_d;
            scan_en_q <= scan_en_d;
            scan_si_q <= scan_si_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SCAN_CTRL_MISR_EN
            sig_q     <= sig_d;
`endif
        end
    end

    assign scan_en  = scan_en_q;
    assign scan_si  = scan_si_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl with a 4-cell scan chain model on the scan outputs.
module tb_scan_ctrl;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = 4'b0000;
    logic         scan_so;
    logic         scan_en;
    logic         scan_si;
    logic         busy;
    logic         done;
    logic [N-1:0] response;

    logic [N-1:0] chain = 4'b0000;
    logic [N-1:0] sd_const = 4'b1010;
    logic         sd_hold = 1'b0;
    logic [N-1:0] model_sig = 4'b0000;

    int n_checks = 0;
    int n_fail = 0;

    scan_ctrl #(.CHAIN_LEN(N), .MISR_POLY(4'b0011)) dut (
        .clock(clock), .reset(reset), .start(start), .pattern(pattern),
        .scan_so(scan_so), .scan_en(scan_en), .scan_si(scan_si),
        .busy(busy), .done(done), .response(response)
    );

    always #5 clock = ~clock;

    // Chain of scanff cells: shift on SE=1, load SD (constant or own Q) on SE=0.
    always @(posedge clock) begin
        if (scan_en) chain <= {chain[N-2:0], scan_si};
        else         chain <= sd_hold ? chain : sd_const;
    end
    assign scan_so = chain[N-1];

    // Expected response for a captured chain value (raw unload, or signature).
    task automatic model_resp(input logic [N-1:0] cap, output logic [N-1:0] r);
`ifdef SCAN_CTRL_MISR_EN
        logic msb;
        for (int i = N - 1; i >= 0; i--) begin
            msb = model_sig[N-1];
            model_sig = {model_sig[N-2:0], 1'b0} ^ ({N{msb}} & 4'b0011) ^ {3'b000, cap[i]};
        end
        r = model_sig;
`else
        r = cap;
`endif
    endtask

    // Present start for edge 0; returns at the sampling point of cycle 1.
    task automatic launch(input logic [N-1:0] p);
        start = 1'b1;
        pattern = p;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (scan_en !== 1'b0) begin n_fail++; $display("FAIL reset_scan_en got %b want 0", scan_en); end
        n_checks++; if (scan_si !== 1'b0) begin n_fail++; $display("FAIL reset_scan_si got %b want 0", scan_si); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (response !== 4'b0000) begin n_fail++; $display("FAIL reset_response got %b want 0000", response); end
        model_sig = 4'b0000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_stimulus;
        logic [N-1:0] p;
        logic [N-1:0] exp_r;
        logic exp_en, exp_si, exp_busy, exp_done;
        p = 4'b0011;
        sd_hold = 1'b0;
        model_resp(4'b1010, exp_r);
        launch(p);
        for (int c = 1; c <= 11; c++) begin
            exp_en   = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
            exp_si   = (c <= 4) ? p[4-c] : 1'b0;
            exp_busy = (c <= 10);
            exp_done = (c == 10);
            n_checks++; if (scan_en !== exp_en) begin n_fail++; $display("FAIL stim_scan_en cycle %0d got %b want %b", c, scan_en, exp_en); end
            n_checks++; if (scan_si !== exp_si) begin n_fail++; $display("FAIL stim_scan_si cycle %0d got %b want %b", c, scan_si, exp_si); end
            n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL stim_busy cycle %0d got %b want %b", c, busy, exp_busy); end
            n_checks++; if (done !== exp_done) begin n_fail++; $display("FAIL stim_done cycle %0d got %b want %b", c, done, exp_done); end
            if (c == 5) begin
                n_checks++; if (chain !== 4'b0011) begin n_fail++; $display("FAIL stim_chain_loaded got %b want 0011", chain); end
            end
            if (c >= 10) begin
                n_checks++; if (response !== exp_r) begin n_fail++; $display("FAIL stim_response cycle %0d got %b want %b", c, response, exp_r); end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_hold_chain;
        logic [N-1:0] exp_r;
        sd_hold = 1'b1;
        model_resp(4'b0110, exp_r);
        launch(4'b0110);
        repeat (9) @(negedge clock);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL hold_done got %b want 1", done); end
        n_checks++; if (response !== exp_r) begin n_fail++; $display("FAIL hold_response got %b want %b", response, exp_r); end
        @(negedge clock);
        sd_hold = 1'b0;
    endtask

    task automatic test_ignored_start;
        logic [N-1:0] prev_r;
        logic [N-1:0] exp_r;
        prev_r = response;
        model_resp(4'b1010, exp_r);
        launch(4'b0011);
        @(negedge clock);
        @(negedge clock);
        start = 1'b1; pattern = 4'b1100;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (scan_si !== 1'b1) begin n_fail++; $display("FAIL ign_scan_si_c4 got %b want 1", scan_si); end
        @(negedge clock);
        n_checks++; if (response !== prev_r) begin n_fail++; $display("FAIL ign_response_held got %b want %b", response, prev_r); end
        repeat (5) @(negedge clock);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ign_done_c10 got %b want 1", done); end
        n_checks++; if (response !== exp_r) begin n_fail++; $display("FAIL ign_response got %b want %b", response, exp_r); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_c11 got %b want 0", busy); end
        @(negedge clock);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_c12 got %b want 0", busy); end
        model_resp(4'b1010, exp_r);
        launch(4'b0101);
        n_checks++; if (busy !== 1'b1 || scan_en !== 1'b1) begin n_fail++; $display("FAIL b2b_start busy=%b scan_en=%b want 1 1", busy, scan_en); end
        repeat (9) @(negedge clock);
        n_checks++; if (done !== 1'b1 || response !== exp_r) begin n_fail++; $display("FAIL b2b_done done=%b resp=%b want 1 %b", done, response, exp_r); end
        @(negedge clock);
    endtask

    task automatic test_mid_reset;
        logic seen_done;
        logic [N-1:0] exp_r;
        launch(4'b0011);
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (scan_en !== 1'b1) begin n_fail++; $display("FAIL mid_scan_en_pre got %b want 1", scan_en); end
        reset = 1'b1;
        #1;
        n_checks++; if (scan_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear scan_en=%b busy=%b want 0 0", scan_en, busy); end
        n_checks++; if (response !== 4'b0000) begin n_fail++; $display("FAIL mid_response_clear got %b want 0000", response); end
        model_sig = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
            @(negedge clock);
        end
        n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done got activity=%b want 0", seen_done); end
        sd_hold = 1'b1;
        model_resp(4'b1001, exp_r);
        launch(4'b1001);
        repeat (9) @(negedge clock);
        n_checks++; if (done !== 1'b1 || response !== exp_r) begin n_fail++; $display("FAIL mid_fresh done=%b resp=%b want 1 %b", done, response, exp_r); end
        @(negedge clock);
        sd_hold = 1'b0;
    endtask

`ifdef SCAN_CTRL_MISR_EN
    task automatic test_misr_back_to_back;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_sig = 4'b0000;
        sd_hold = 1'b0;
        launch(4'b0000);
        repeat (9) @(negedge clock);
        n_checks++; if (response !== 4'b1010) begin n_fail++; $display("FAIL misr_first got %b want 1010", response); end
        @(negedge clock);
        launch(4'b0000);
        repeat (9) @(negedge clock);
        n_checks++; if (response !== 4'b0111) begin n_fail++; $display("FAIL misr_second got %b want 0111", response); end
        @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_stimulus();
        test_hold_chain();
        test_ignored_start();
        test_mid_reset();
`ifdef SCAN_CTRL_MISR_EN
        test_misr_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
